// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, drives the ROM index and
// buffers {pc, instr} pairs in a small FIFO toward decode. A redirect
// flushes the queue and restarts fetch at the word-aligned target.

`ifndef CPU_PC_SIZE
`define CPU_PC_SIZE 32
`endif
`ifndef CPU_INSTR_SIZE
`define CPU_INSTR_SIZE 32
`endif
`ifndef CPU_PC_RST_IDX
`define CPU_PC_RST_IDX 0
`endif

module if_fetch_queue #(
  parameter int unsigned        PC_LEN    = `CPU_PC_SIZE,
  parameter int unsigned        INSTR_LEN = `CPU_INSTR_SIZE,
  parameter logic [PC_LEN-1:0]  RST_PC    = PC_LEN'(`CPU_PC_RST_IDX),
  parameter int unsigned        DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_en_i,
  output logic [PC_LEN-1:0]    rom_idx_o,
  input  logic [INSTR_LEN-1:0] rom_data_i,
  input  logic                 redirect_valid_i,
  input  logic [PC_LEN-1:0]    redirect_pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PC_LEN-1:0]    out_pc_o,
  output logic [INSTR_LEN-1:0] out_instr_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_LEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PC_LEN-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_LEN-1:0] instr_mem_q [DEPTH];

  logic full;
  logic pop;
  logic push;

  // Redirect targets are word aligned; the low bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Handshake decode: a push into a full queue needs a same-cycle pop.
  always_comb begin
    full = (count_q == CNT_W'(DEPTH));
    pop  = out_valid_o & out_ready_i;
    push = fetch_en_i & ~redirect_valid_i & (~full | pop);
  end

  // Next-state for PC, pointers and occupancy; redirect wins over all.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid_i) begin
      fetch_pc_d = {redirect_pc_i[PC_LEN-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + PC_LEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RST_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; contents are only observable while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= rom_data_i;
    end
  end

  // Outputs decoded from registered state; head fields zeroed when empty.
  always_comb begin
    rom_idx_o   = fetch_pc_q;
    out_valid_o = (count_q != '0);
    out_pc_o    = '0;
    out_instr_o = '0;
    if (out_valid_o) begin
      out_pc_o    = pc_mem_q[rd_ptr_q];
      out_instr_o = instr_mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, a redirect corner
// sequence and randomized traffic against a queue-based reference model.

module tb_if_fetch_queue;

  localparam int unsigned PC_LEN    = 32;
  localparam int unsigned INSTR_LEN = 32;
  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] RST_PC    = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] rom_idx_o;
  logic [31:0] rom_data_i;
  logic        out_valid_o;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_queue #(
    .PC_LEN(PC_LEN), .INSTR_LEN(INSTR_LEN), .RST_PC(RST_PC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en_i),
    .rom_idx_o(rom_idx_o), .rom_data_i(rom_data_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_instr_o(out_instr_o)
  );

  always #5 clk = ~clk;

  // ROM contents differ from the index so pc/instr mixups are visible.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    return {idx[15:0], idx[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign rom_data_i = rom_word(rom_idx_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_rom;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic rd, input logic rv,
                              input logic [31:0] rp, input logic ev,
                              input logic [31:0] ep, input logic [31:0] er);
    vec_t v;
    v.rst = r; v.en = e; v.rdy = rd; v.redir = rv; v.rpc = rp;
    v.exp_valid = ev; v.exp_pc = ep; v.exp_rom = er;
    return v;
  endfunction

  // Reference model: a plain queue of fetched {pc, instr} pairs.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  task automatic step(input logic r, input logic e, input logic rd,
                      input logic rv, input logic [31:0] rp);
    bit          m_pop;
    bit          m_push;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    rst_n = r; fetch_en_i = e; out_ready_i = rd;
    redirect_valid_i = rv; redirect_pc_i = rp;
    m_pop  = (mq.size() != 0) && rd;
    m_push = e && !rv && ((mq.size() < int'(DEPTH)) || m_pop);
    if (!r) begin
      mq.delete();
      m_pc = RST_PC;
    end else if (rv) begin
      mq.delete();
      m_pc = rp & ~32'h3;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back('{m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    exp_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
    exp_instr = (mq.size() != 0) ? mq[0].instr : 32'h0;
    check("model valid", 32'(out_valid_o), 32'(mq.size() != 0));
    check("model pc", out_pc_o, exp_pc);
    check("model instr", out_instr_o, exp_instr);
    check("model rom_idx", rom_idx_o, m_pc);
  endtask

  vec_t vecs[26];

  initial begin
    // Directed table: each row is applied for one edge, then outputs checked.
    vecs[0]  = mk(0,1,1,0,0,            0, 32'h0,        32'h100);
    vecs[1]  = mk(1,1,1,0,0,            1, 32'h100,      32'h104);
    vecs[2]  = mk(1,1,1,0,0,            1, 32'h104,      32'h108);
    vecs[3]  = mk(1,1,1,0,0,            1, 32'h108,      32'h10C);
    vecs[4]  = mk(1,1,0,0,0,            1, 32'h108,      32'h110);
    vecs[5]  = mk(1,1,0,0,0,            1, 32'h108,      32'h114);
    vecs[6]  = mk(1,1,0,0,0,            1, 32'h108,      32'h118);
    vecs[7]  = mk(1,1,0,0,0,            1, 32'h108,      32'h118);
    vecs[8]  = mk(1,1,0,0,0,            1, 32'h108,      32'h118);
    vecs[9]  = mk(1,1,0,0,0,            1, 32'h108,      32'h118);
    vecs[10] = mk(1,1,1,0,0,            1, 32'h10C,      32'h11C);
    vecs[11] = mk(1,1,1,0,0,            1, 32'h110,      32'h120);
    vecs[12] = mk(1,0,1,0,0,            1, 32'h114,      32'h120);
    vecs[13] = mk(1,0,1,0,0,            1, 32'h118,      32'h120);
    vecs[14] = mk(1,0,1,0,0,            1, 32'h11C,      32'h120);
    vecs[15] = mk(1,0,1,0,0,            0, 32'h0,        32'h120);
    vecs[16] = mk(1,1,1,0,0,            1, 32'h120,      32'h124);
    vecs[17] = mk(1,1,1,1,32'h1236,     0, 32'h0,        32'h1234);
    vecs[18] = mk(1,1,1,0,0,            1, 32'h1234,     32'h1238);
    vecs[19] = mk(1,1,1,0,0,            1, 32'h1238,     32'h123C);
    vecs[20] = mk(1,1,1,1,32'hFFFFFFFF, 0, 32'h0,        32'hFFFFFFFC);
    vecs[21] = mk(1,1,1,0,0,            1, 32'hFFFFFFFC, 32'h0);
    vecs[22] = mk(1,1,1,0,0,            1, 32'h0,        32'h4);
    vecs[23] = mk(1,1,0,0,0,            1, 32'h0,        32'h8);
    vecs[24] = mk(0,1,0,0,0,            0, 32'h0,        32'h100);
    vecs[25] = mk(1,1,1,0,0,            1, 32'h100,      32'h104);

    for (int i = 0; i < 26; i++) begin
      rst_n = vecs[i].rst; fetch_en_i = vecs[i].en; out_ready_i = vecs[i].rdy;
      redirect_valid_i = vecs[i].redir; redirect_pc_i = vecs[i].rpc;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d valid", i), 32'(out_valid_o), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d pc", i), out_pc_o, vecs[i].exp_pc);
      check($sformatf("vec%0d instr", i), out_instr_o,
            vecs[i].exp_valid ? rom_word(vecs[i].exp_pc) : 32'h0);
      check($sformatf("vec%0d rom_idx", i), rom_idx_o, vecs[i].exp_rom);
    end

    // Redirect with three entries queued and decode ready.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1236);
    check("redir valid low", 32'(out_valid_o), 32'h0);
    check("redir rom_idx", rom_idx_o, 32'h0000_1234);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("redir first pc", out_pc_o, 32'h0000_1234);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check("redir no stale", 32'(out_pc_o >= 32'h0000_1234), 32'h1);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        e;
      logic        rd;
      logic        rv;
      logic [31:0] rp;
      r  = ($urandom_range(99) != 0);
      e  = ($urandom_range(9) < 8);
      rd = ($urandom_range(9) < 6);
      rv = ($urandom_range(19) == 0);
      rp = $urandom_range(1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
      step(r, e, rd, rv, rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
